// File: rtl/pll_reset_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_reset_pkg;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_FILTER = 2'd1,
        ST_HOLD   = 2'd2,
        ST_RUN    = 2'd3
    } seq_state_t;

    // Bits needed to hold any value in 0..max_val without wrapping.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Parameterised-depth single-bit synchroniser for asynchronous board inputs.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Debounces PLL lock and releases staged domain resets; re-sequences on lock loss.
//
//   state  | meaning
//   WAIT   | lock not seen, all resets asserted
//   FILTER | lock seen, counting consecutive high cycles
//   HOLD   | lock trusted, releasing stages one by one
//   RUN    | all stages released, ready high
module pll_reset_sequencer
    import pll_reset_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_FILTER = 1024,
    parameter int RESET_HOLD  = 16,
    parameter int STAGE_GAP   = 4,
    parameter int NUM_STAGES  = 2,
    parameter int CNT_W       = 8
) (
    input  logic                  clk_100mhz,
    input  logic                  rst_n,
    input  logic                  locked,
    input  logic                  soft_rst,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  ready,
    output logic [CNT_W-1:0]      loss_count,
    output logic [1:0]            state
);

    localparam int HOLD_MAX = RESET_HOLD - 1 + (NUM_STAGES - 1) * STAGE_GAP;
    localparam int FW       = cnt_width(LOCK_FILTER);
    localparam int HW       = cnt_width(HOLD_MAX);

    localparam logic [FW-1:0]    FILTER_TC = FW'(LOCK_FILTER - 1);
    localparam logic [HW-1:0]    HOLD_TC   = HW'(HOLD_MAX);
    localparam logic [CNT_W-1:0] LOSS_MAX  = '1;

    logic          lock_s;
    seq_state_t    st;
    logic [FW-1:0] filt_cnt;
    logic [HW-1:0] hold_cnt;

    sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk_sys (clk_100mhz),
        .rst_n   (rst_n),
        .d       (locked),
        .q       (lock_s)
    );

    assign state = st;

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            st          <= ST_WAIT;
            filt_cnt    <= '0;
            hold_cnt    <= '0;
            stage_rst_n <= '0;
            ready       <= 1'b0;
            loss_count  <= '0;
        end else if (!lock_s && (st == ST_HOLD || st == ST_RUN)) begin
            // Lock loss takes priority over a coincident soft reset.
            st          <= ST_WAIT;
            filt_cnt    <= '0;
            hold_cnt    <= '0;
            stage_rst_n <= '0;
            ready       <= 1'b0;
            if (loss_count != LOSS_MAX) begin
                loss_count <= loss_count + 1'b1;
            end
        end else if (soft_rst) begin
            st          <= lock_s ? ST_HOLD : ST_WAIT;
            filt_cnt    <= '0;
            hold_cnt    <= '0;
            stage_rst_n <= '0;
            ready       <= 1'b0;
        end else begin
            case (st)
                ST_WAIT: begin
                    filt_cnt <= '0;
                    if (lock_s) begin
                        if (LOCK_FILTER == 1) begin
                            st       <= ST_HOLD;
                            hold_cnt <= '0;
                        end else begin
                            st       <= ST_FILTER;
                            filt_cnt <= FW'(1);
                        end
                    end
                end
                ST_FILTER: begin
                    if (!lock_s) begin
                        st       <= ST_WAIT;
                        filt_cnt <= '0;
                    end else if (filt_cnt == FILTER_TC) begin
                        st       <= ST_HOLD;
                        filt_cnt <= '0;
                        hold_cnt <= '0;
                    end else begin
                        filt_cnt <= filt_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    for (int k = 0; k < NUM_STAGES; k++) begin
                        if (hold_cnt == HW'(RESET_HOLD - 1 + k * STAGE_GAP)) begin
                            stage_rst_n[k] <= 1'b1;
                        end
                    end
                    // Counter parks on the last release value instead of wrapping.
                    if (hold_cnt == HOLD_TC) begin
                        st    <= ST_RUN;
                        ready <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: stimulus queues expectations, monitor compares.
module tb_pll_reset_sequencer;

    logic       clk_100mhz = 1'b0;
    logic       rst_n;
    logic       locked;
    logic       soft_rst;
    logic [1:0] stage_rst_n;
    logic       ready;
    logic [1:0] loss_count;
    logic [1:0] state;

    pll_reset_sequencer #(
        .SYNC_STAGES (2),
        .LOCK_FILTER (8),
        .RESET_HOLD  (4),
        .STAGE_GAP   (2),
        .NUM_STAGES  (2),
        .CNT_W       (2)
    ) dut (
        .clk_100mhz  (clk_100mhz),
        .rst_n       (rst_n),
        .locked      (locked),
        .soft_rst    (soft_rst),
        .stage_rst_n (stage_rst_n),
        .ready       (ready),
        .loss_count  (loss_count),
        .state       (state)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    typedef struct {
        int         cyc;
        string      name;
        logic [1:0] srn;
        logic       rdy;
        logic [1:0] st;
        logic [1:0] loss;
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   n_total = 0;
    int   n_pass  = 0;
    event sample_now;

    initial forever begin
        @(posedge clk_100mhz);
        cyc++;
    end

    task automatic compare(input exp_t e);
        n_total++;
        if ({stage_rst_n, ready, state, loss_count} === {e.srn, e.rdy, e.st, e.loss}) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got stage_rst_n=%b ready=%b state=%0d loss=%0d, want stage_rst_n=%b ready=%b state=%0d loss=%0d",
                     e.name, stage_rst_n, ready, state, loss_count, e.srn, e.rdy, e.st, e.loss);
        end
    endtask

    // Monitor: compares every queued expectation whose cycle has arrived.
    initial forever begin
        @(negedge clk_100mhz or sample_now);
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc < 0 || q[i].cyc == cyc) begin
                compare(q[i]);
                q.delete(i);
            end else if (q[i].cyc < cyc) begin
                n_total++;
                $display("FAIL %s: check missed at cycle %0d, required at cycle %0d", q[i].name, cyc, q[i].cyc);
                q.delete(i);
            end
        end
    end

    task automatic push(input int dc, input string nm, input logic [1:0] srn, input logic rdy,
                        input logic [1:0] st, input logic [1:0] loss);
        exp_t e;
        e.cyc  = (dc < 0) ? -1 : cyc + dc;
        e.name = nm;
        e.srn  = srn;
        e.rdy  = rdy;
        e.st   = st;
        e.loss = loss;
        q.push_back(e);
    endtask

    // Called on the negedge where locked has just been raised (E0 is the next edge).
    task automatic seq_lock(input string pfx, input logic [1:0] l);
        push(2,  {pfx, "_e1_wait"},    2'b00, 1'b0, 2'd0, l);
        push(3,  {pfx, "_e2_filter"},  2'b00, 1'b0, 2'd1, l);
        push(9,  {pfx, "_e8_filter"},  2'b00, 1'b0, 2'd1, l);
        push(10, {pfx, "_e9_hold"},    2'b00, 1'b0, 2'd2, l);
        push(13, {pfx, "_e12_hold"},   2'b00, 1'b0, 2'd2, l);
        push(14, {pfx, "_e13_stage0"}, 2'b01, 1'b0, 2'd2, l);
        push(15, {pfx, "_e14_stage0"}, 2'b01, 1'b0, 2'd2, l);
        push(16, {pfx, "_e15_run"},    2'b11, 1'b1, 2'd3, l);
        repeat (18) @(negedge clk_100mhz);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_loss;
        rst_n    = 1'b0;
        locked   = 1'b0;
        soft_rst = 1'b0;
        #1;
        push(-1, "reset_values", 2'b00, 1'b0, 2'd0, 2'd0);
        -> sample_now;
        repeat (3) @(negedge clk_100mhz);
        rst_n = 1'b1;
        push(3, "idle_wait", 2'b00, 1'b0, 2'd0, 2'd0);
        repeat (4) @(negedge clk_100mhz);

        locked = 1'b1;
        seq_lock("clean", 2'd0);

        locked = 1'b0;
        push(2, "loss_e1_run",  2'b11, 1'b1, 2'd3, 2'd0);
        push(3, "loss_e2_wait", 2'b00, 1'b0, 2'd0, 2'd1);
        repeat (5) @(negedge clk_100mhz);
        locked = 1'b1;
        seq_lock("relock", 2'd1);

        soft_rst = 1'b1;
        push(1, "soft_e0_hold",   2'b00, 1'b0, 2'd2, 2'd1);
        push(4, "soft_e3_hold",   2'b00, 1'b0, 2'd2, 2'd1);
        push(5, "soft_e4_stage0", 2'b01, 1'b0, 2'd2, 2'd1);
        push(6, "soft_e5_stage0", 2'b01, 1'b0, 2'd2, 2'd1);
        push(7, "soft_e6_run",    2'b11, 1'b1, 2'd3, 2'd1);
        @(negedge clk_100mhz);
        soft_rst = 1'b0;
        repeat (9) @(negedge clk_100mhz);

        locked = 1'b0;
        push(2, "coinc_e1_run",  2'b11, 1'b1, 2'd3, 2'd1);
        push(3, "coinc_e2_wait", 2'b00, 1'b0, 2'd0, 2'd2);
        repeat (2) @(negedge clk_100mhz);
        soft_rst = 1'b1;
        @(negedge clk_100mhz);
        soft_rst = 1'b0;
        repeat (3) @(negedge clk_100mhz);

        locked = 1'b1;
        push(6, "bounce_filter", 2'b00, 1'b0, 2'd1, 2'd2);
        push(8, "bounce_wait",   2'b00, 1'b0, 2'd0, 2'd2);
        repeat (5) @(negedge clk_100mhz);
        locked = 1'b0;
        @(negedge clk_100mhz);
        locked = 1'b1;
        seq_lock("bounce", 2'd2);

        soft_rst = 1'b1;
        push(1, "ar_hold",   2'b00, 1'b0, 2'd2, 2'd2);
        push(5, "ar_stage0", 2'b01, 1'b0, 2'd2, 2'd2);
        @(negedge clk_100mhz);
        soft_rst = 1'b0;
        repeat (4) @(negedge clk_100mhz);
        #2;
        rst_n = 1'b0;
        #1;
        push(-1, "async_rst", 2'b00, 1'b0, 2'd0, 2'd0);
        -> sample_now;
        @(negedge clk_100mhz);
        push(1, "async_rst_held", 2'b00, 1'b0, 2'd0, 2'd0);
        @(negedge clk_100mhz);
        rst_n = 1'b1;
        seq_lock("rerun", 2'd0);

        for (int i = 0; i < 5; i++) begin
            exp_loss = (i + 1 > 3) ? 3 : i + 1;
            locked = 1'b0;
            push(2, $sformatf("sat%0d_run", i),  2'b11, 1'b1, 2'd3, 2'(i > 3 ? 3 : i));
            push(3, $sformatf("sat%0d_loss", i), 2'b00, 1'b0, 2'd0, 2'(exp_loss));
            repeat (4) @(negedge clk_100mhz);
            locked = 1'b1;
            seq_lock($sformatf("sat%0d_relock", i), 2'(exp_loss));
        end

        for (int w = 0; w < 50 && q.size() > 0; w++) @(negedge clk_100mhz);
        while (q.size() > 0) begin
            n_total++;
            $display("FAIL %s: never compared, required at cycle %0d", q[0].name, q[0].cyc);
            void'(q.pop_front());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Consumes the asynchronous `locked` output of the board PLL and generates clean reset releases for the 100 MHz fabric.
- Synchronises and debounces `locked`, then releases per-domain resets in a fixed stagger (display driver first, pattern logic after).
- On lock loss, immediately re-asserts all resets, counts the event and re-sequences.
- Sits directly after the PLL wrapper at top level.

Parameters:
SYNC_STAGES, 2, flops in the `locked` synchroniser chain (>=2)
LOCK_FILTER, 1024, consecutive synchronised-high cycles required before leaving FILTER (>=1)
RESET_HOLD, 16, cycles in HOLD before stage 0 release (>=1)
STAGE_GAP, 4, cycles between successive stage releases (>=1)
NUM_STAGES, 2, number of staged reset outputs (>=1)
CNT_W, 8, width of the lock-loss counter

Ports:
clk_100mhz  in  1  PLL output clock; all logic on its rising edge
rst_n  in  1  asynchronous active-low reset
locked  in  1  PLL lock, asynchronous to clk_100mhz
soft_rst  in  1  synchronous one-cycle request to re-run the sequence
stage_rst_n  out  NUM_STAGES  active-low domain resets; bit 0 released first
ready  out  1  high when all stages are released (state RUN)
loss_count  out  CNT_W  saturating count of lock losses in HOLD/RUN
state  out  2  debug: 0 WAIT, 1 FILTER, 2 HOLD, 3 RUN

Behaviour:
- One clock; reset is asynchronous and active-low (`rst_n`), clock `clk_100mhz`.
- While `rst_n`=0:
  - synchroniser flops, counters and `loss_count` = 0
  - `stage_rst_n` = all 0, `ready` = 0, `state` = WAIT
- All outputs are registered.
- Synchroniser: `locked` passes through SYNC_STAGES flops to give `lock_s`. Only `lock_s` is used.
- WAIT: filter counter = 0.
  - `lock_s`=1 -> FILTER, filter counter = 1.
- FILTER: `lock_s`=0 -> WAIT, counter cleared, no loss counted.
  - Otherwise the counter increments.
  - On the edge where the counter would reach LOCK_FILTER -> HOLD, hold counter = 0.
  - With LOCK_FILTER=1, WAIT goes directly to HOLD.
- HOLD: the hold counter increments each cycle.
  - `stage_rst_n[k]` goes to 1 on the edge where the counter equals RESET_HOLD-1 + k*STAGE_GAP.
  - On the last stage's release edge: state -> RUN and `ready` -> 1 on that same edge.
- RUN: outputs are held.
- Lock loss (`lock_s`=0 in HOLD or RUN), on the next edge:
  - all `stage_rst_n` = 0, `ready` = 0
  - `loss_count` += 1, saturating at 2^CNT_W-1
  - state -> WAIT
- `soft_rst`=1 (any state, no lock loss that cycle), on the next edge:
  - all `stage_rst_n` = 0, `ready` = 0
  - if `lock_s`=1 -> HOLD with hold counter 0 (filter skipped); else -> WAIT
  - `loss_count` unchanged
- Simultaneous lock loss and `soft_rst`: lock loss wins (count increments, WAIT).
- Counters never wrap. Counter widths are sized by $clog2 of the maximum terminal value plus 1.
- `rst_n` asserted mid-sequence: immediate asynchronous return to reset values, including `loss_count`.
- `stage_rst_n` bits never de-assert out of order, and never glitch high during FILTER.

Decomposition:
- Package `pll_reset_pkg`:
  - state enum typedef (WAIT/FILTER/HOLD/RUN, 2-bit)
  - localparam helper function for counter width
- Sub-module `sync_ff` (parameterised-depth single-bit synchroniser, async active-low reset to 0). It is reusable for the other board inputs (buttons).

Test Plan:
Defaults for all scenarios unless stated: SYNC_STAGES=2, LOCK_FILTER=8, RESET_HOLD=4, STAGE_GAP=2, NUM_STAGES=2. E0 = first edge sampling `locked`=1.
- Clean lock: `locked` rises and stays high -> `state`=FILTER after E2, HOLD after E9; `stage_rst_n`=01 after E13; 11 with `ready`=1 after E15; `loss_count`=0.
- Bounce: `locked` high 5 cycles, low 1, then high -> returns to WAIT, `loss_count`=0; release timing restarts from the second rise (stage 0 at 13 edges after it).
- Lock loss in RUN: drop `locked` -> two edges later `stage_rst_n`=00, `ready`=0, `loss_count`=1, `state`=WAIT; re-lock re-sequences identically.
- Saturation: CNT_W=2, 5 lock-loss events -> `loss_count` reads 1,2,3,3,3.
- soft_rst in RUN with lock stable -> next edge `stage_rst_n`=00, HOLD; stage 0 back after 4 more edges, `ready` after 6; `loss_count` unchanged. `soft_rst` coincident with lock loss -> WAIT, count +1.
- `rst_n` pulsed low mid-HOLD (asynchronous, between edges) -> outputs 0 immediately without a clock edge; sequence restarts from WAIT after release.
